// File: rtl/tsb_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin TSB mux arbiter.
// State encoding plus a small one-hot helper used by the top.
package tsb_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETTLE,
    ARB_GRANT,
    ARB_GAP
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/tsb_mux_arbiter_if.sv
// Requester-side handshake bundle for the TSB mux arbiter.
// slave modport is the arbiter's view; master is the requesters' view.
interface tsb_mux_arbiter_if;
  import tsb_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               sel_valid;
  logic               busy;

  modport master (
    output req, done,
    input  gnt, sel, sel_valid, busy
  );

  modport slave (
    input  req, done,
    output gnt, sel, sel_valid, busy
  );

endinterface

// File: rtl/tsb_mux_arbiter_rr_pick4.sv
// Combinational rotate-priority picker: first set req bit at or above ptr,
// wrapping 3->0.
module rr_pick4
  import tsb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tsb_mux_arbiter.sv
// Round-robin arbiter for a shared 4:1 tristate mux with break-before-make:
// select is set one cycle ahead of grant and dead cycles separate owners.
module tsb_mux_arbiter
  import tsb_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX   = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  tsb_mux_arbiter_if.slave   arb
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               sel_valid_q, sel_valid_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               release_now;

  rr_pick4 u_pick (
    .req (arb.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Any combination of req drop, done and hold expiry collapses into one release.
  assign release_now = !arb.req[sel_q] || arb.done[sel_q] || (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    sel_valid_d = sel_valid_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ARB_SETTLE;
        end
      end
      ARB_SETTLE: begin
        gnt_d       = onehot(sel_q);
        sel_valid_d = 1'b1;
        hold_cnt_d  = '0;
        state_d     = ARB_GRANT;
      end
      ARB_GRANT: begin
        if (release_now) begin
          gnt_d       = '0;
          sel_valid_d = 1'b0;
          ptr_d       = sel_q + SEL_W'(1);
          gap_cnt_d   = '0;
          state_d     = ARB_GAP;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ARB_GAP: begin
        gap_cnt_d = gap_cnt_q + CNT_W'(1);
        if (gap_cnt_q == GAP_LAST) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      sel_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      sel_valid_q <= sel_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.sel       = sel_q;
  assign arb.sel_valid = sel_valid_q;
  assign arb.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_tsb_mux_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against an owner/pending/cooldown model of the arbitration rules.
module tb_tsb_mux_arbiter;

  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tsb_mux_arbiter_if bus ();

  tsb_mux_arbiter #(
    .HOLD_MAX   (HOLD),
    .GAP_CYCLES (GAP),
    .CNT_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  // Behavioural mux_4to1 stand-in: a=0, b=1, c=1, d=0.
  logic [3:0] mux_in = 4'b0110;
  logic       w;
  assign w = mux_in[bus.sel];

  int n_checks = 0;
  int n_err    = 0;

  // Model: who owns the mux, who is waiting out SETTLE, how many dead cycles remain.
  int m_owner   = -1;
  int m_pending = -1;
  int m_cool    = 0;
  int m_held    = 0;
  int m_ptr     = 0;
  int m_sel     = 0;

  logic [1:0] prev_sel   = '0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    if (rs) begin
      m_owner = -1; m_pending = -1; m_cool = 0; m_held = 0; m_ptr = 0; m_sel = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      if (!r[m_owner] || d[m_owner] || m_held == HOLD) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cool  = GAP;
      end
    end else if (m_pending >= 0) begin
      m_owner   = m_pending;
      m_pending = -1;
      m_held    = 0;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (r != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (m_pending < 0 && r[(m_ptr + k) % 4]) m_pending = (m_ptr + k) % 4;
      end
      m_sel = m_pending;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", 8'(bus.gnt), 8'(exp_gnt));
    chk("sel", 8'(bus.sel), 8'(m_sel));
    chk("sel_valid", 8'(bus.sel_valid), 8'(m_owner >= 0));
    chk("busy", 8'(bus.busy), 8'(m_owner >= 0 || m_pending >= 0 || m_cool > 0));
    if (prev_valid && bus.sel_valid) chk("sel_stable", 8'(bus.sel), 8'(prev_sel));
    if (bus.sel_valid && m_owner >= 0) chk("mux_w", 8'(w), 8'(mux_in[m_owner]));
    prev_sel   = bus.sel;
    prev_valid = bus.sel_valid;
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic rs);
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    check_outputs();
  endtask

  function automatic int owner_of(input logic [3:0] g);
    int o;
    o = -1;
    for (int i = 0; i < 4; i++) if (g[i]) o = i;
    return o;
  endfunction

  initial begin
    int         order[$];
    int         lens[$];
    int         run;
    logic [3:0] rq;
    logic [3:0] dn;
    logic       rs;

    bus.req  = '0;
    bus.done = '0;

    // 1: reset with all requesting, then first grant goes to 0
    cycle(4'b1111, 4'b0000, 1'b1);
    cycle(4'b1111, 4'b0000, 1'b1);
    chk("reset_gnt", 8'(bus.gnt), 8'h00);
    chk("reset_busy", 8'(bus.busy), 8'h00);
    cycle(4'b1111, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b0);
    chk("first_grant", 8'(bus.gnt), 8'h01);

    // 2: single requester latency, drop, then 3 beats 0
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("lat_sel", 8'(bus.sel), 8'h02);
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("lat_gnt", 8'(bus.gnt), 8'h04);
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("drop_gnt", 8'(bus.gnt), 8'h00);
    for (int i = 0; i < 4; i++) cycle(4'b1001, 4'b0000, 1'b0);
    chk("rr_3_over_0", 8'(bus.gnt), 8'h08);

    // 3: all requesting, grant order and hold length
    cycle(4'b0000, 4'b0000, 1'b1);
    run = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(4'b1111, 4'b0000, 1'b0);
      if (bus.gnt != 4'b0000) begin
        if (run == 0) order.push_back(owner_of(bus.gnt));
        run++;
      end else if (run != 0) begin
        lens.push_back(run);
        run = 0;
      end
    end
    chk("order_count_ok", 8'(order.size() >= 5), 8'h01);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("order", 8'(order[i]), 8'(i % 4));
    for (int i = 0; i < lens.size(); i++) chk("hold_len", 8'(lens[i]), 8'(HOLD));

    // 4: done from non-owner ignored, owner done releases, done+drop single release
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0010, 1'b0);
    chk("done_other", 8'(bus.gnt), 8'h01);
    cycle(4'b0001, 4'b0001, 1'b0);
    chk("done_own", 8'(bus.gnt), 8'h00);
    for (int i = 0; i < 4; i++) cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0001, 1'b0);
    chk("done_drop", 8'(bus.gnt), 8'h00);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("done_drop_idle", 8'(bus.busy), 8'h00);

    // 5: reset mid-grant of owner 3, then ptr back to 0
    for (int i = 0; i < 3; i++) cycle(4'b1000, 4'b0000, 1'b0);
    chk("owner3", 8'(bus.gnt), 8'h08);
    cycle(4'b1000, 4'b0000, 1'b1);
    chk("rst_mid_valid", 8'(bus.sel_valid), 8'h00);
    chk("rst_mid_sel", 8'(bus.sel), 8'h00);
    cycle(4'b1010, 4'b0000, 1'b0);
    cycle(4'b1010, 4'b0000, 1'b0);
    chk("after_rst_grant", 8'(bus.gnt), 8'h02);

    // 6: random traffic against the model
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      dn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rs = ($urandom_range(0, 99) == 0);
      cycle(rq, dn, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
